// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide on magnitudes, sign fix-up at the end.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg_in;
  logic              b_neg_in;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic              no_borrow;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin;

  // Hold the pipeline while an accepted op is still in flight.
  assign stall = start & ~done & ~flush & ~rst;

  // Operand decode: signedness, magnitudes and divide special cases.
  always_comb begin
    a_sgn    = (op == 3'b001) | (op == 3'b010)
             | (op[2] & ~op[0]);
    b_sgn    = (op == 3'b001) | (op[2] & ~op[0]);
    a_neg_in = a_sgn & rs1_val[XLEN-1];
    b_neg_in = b_sgn & rs2_val[XLEN-1];
    mag_a    = a_neg_in ? -rs1_val : rs1_val;
    mag_b    = b_neg_in ? -rs2_val : rs2_val;
    div_zero = (rs2_val == '0);
    div_ovf  = a_sgn & b_sgn
             & (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
             & (rs2_val == '1);
    special  = op[2] & (div_zero | div_ovf);
    if (op[1])
      special_res = div_zero ? rs1_val : '0;
    else
      special_res = div_zero ? '1 : rs1_val;
  end

  // One iteration step plus the sign-corrected final result.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]}
              + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    rem_sh    = acc[2*XLEN-1:XLEN-1];
    no_borrow = (rem_sh >= {1'b0, opnd});
    rem_diff  = rem_sh - {1'b0, opnd};
    if (no_borrow)
      div_next = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      div_next = {acc[2*XLEN-2:0], 1'b0};
    nxt      = op_q[2] ? div_next : mul_next;
    prod_fix = (a_neg ^ b_neg) ? -nxt : nxt;
    quo      = nxt[XLEN-1:0];
    rem      = nxt[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      if (op_q[1])
        fin = a_neg ? -rem : rem;
      else
        fin = (a_neg ^ b_neg) ? -quo : quo;
    end else begin
      if (op_q[1:0] == 2'b00)
        fin = prod_fix[XLEN-1:0];
      else
        fin = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_q   <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op;
            a_neg <= a_neg_in;
            b_neg <= b_neg_in;
            opnd  <= op[2] ? mag_b : mag_a;
            acc   <= {{XLEN{1'b0}}, op[2] ? mag_a : mag_b};
            cnt   <= '0;
            busy  <= 1'b1;
            if (special) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc <= nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) begin
            result <= fin;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
